// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: ALU pass-through, load/store data-memory access, writeback bundle
//
// Purpose:
//   Accepts one executed instruction at a time from the EX stage.
//   - Non-memory ops go straight to writeback with one cycle of latency.
//   - Stores issue one data-memory request and write back once it is accepted.
//   - Loads issue one request, wait for the response, then extract and extend the addressed byte or halfword.
//
// Ports:
//   clk, rst_n       : clock and synchronous active-low reset
//   ex_valid, ex_out : incoming instruction bundle (ex_stage_out_t)
//   ex_ready         : high only when the stage is idle
//   dmem_req_*       : request handshake plus addr/we/be/wdata; all fields are registered and held while waiting
//   dmem_rsp_*       : load response (valid + rdata)
//   wb_*             : single-cycle writeback pulse with rd, data, pc4, rf_en and sel
//   misalign         : misaligned-access flag, meaningful with wb_valid
//
// Build option:
//   MEM_MISALIGN_TRAP_EN - when defined, a misaligned halfword or word access is not issued.
//                          Instead it writes back immediately with misalign=1.
//                          When undefined, misalign is tied low and misaligned accesses are issued
//                          with lanes truncated at the word boundary.

package mem_stage_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsuop_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] opr_b;
        logic [31:0] opr_res;
        logic [31:0] pc4;
        lsuop_e      lsuop;
        logic        rf_en;
        logic        dm_en;
        logic [1:0]  wb_sel;
    } ex_stage_out_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_AW = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ex_valid,
    input  ex_stage_out_t       ex_out,
    output logic                ex_ready,

    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [DMEM_AW-1:0]  dmem_addr,
    output logic                dmem_we,
    output logic [3:0]          dmem_be,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_rsp_valid,
    input  logic [31:0]         dmem_rsp_rdata,

    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [31:0]         wb_data,
    output logic [31:0]         wb_pc4,
    output logic                wb_rf_en,
    output logic [1:0]          wb_sel,
    output logic                misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e               state_q;
    lsuop_e               op_q;
    logic [1:0]           alo_q;

    logic                 dmem_req_valid_q;
    logic [DMEM_AW-1:0]   dmem_addr_q;
    logic                 dmem_we_q;
    logic [3:0]           dmem_be_q;
    logic [31:0]          dmem_wdata_q;

    logic                 wb_valid_q;
    logic [4:0]           wb_rd_q;
    logic [31:0]          wb_data_q;
    logic [31:0]          wb_pc4_q;
    logic                 wb_rf_en_q;
    logic [1:0]           wb_sel_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 misalign_q;
`endif

    function automatic logic is_store(input lsuop_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input lsuop_e op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
        word_op = (op == LSU_LW) || (op == LSU_SW);
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction
`endif

    // Shifting inside 4 bits drops lanes past byte 3.
    // This is what truncates a misaligned halfword at the word boundary.
    function automatic logic [3:0] store_be(input lsuop_e op, input logic [1:0] a);
        case (op)
            LSU_SB:  return 4'b0001 << a;
            LSU_SH:  return 4'b0011 << a;
            LSU_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Data is replicated into every lane so memory can pick the lane by byte enable alone.
    function automatic logic [31:0] store_wdata(input lsuop_e op, input logic [31:0] b);
        case (op)
            LSU_SB:  return {4{b[7:0]}};
            LSU_SH:  return {2{b[15:0]}};
            LSU_SW:  return b;
            default: return 32'h0;
        endcase
    endfunction

    // A halfword at offset 3 only has one byte inside the word.
    // Its upper byte reads as zero.
    function automatic logic [31:0] load_data(input lsuop_e op, input logic [1:0] a,
                                              input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    begin b = rdata[7:0];   h = rdata[15:0];          end
            2'd1:    begin b = rdata[15:8];  h = rdata[23:8];          end
            2'd2:    begin b = rdata[23:16]; h = rdata[31:16];         end
            default: begin b = rdata[31:24]; h = {8'h00, rdata[31:24]}; end
        endcase
        case (op)
            LSU_LB:  return {{24{b[7]}}, b};
            LSU_LBU: return {24'h0, b};
            LSU_LH:  return {{16{h[15]}}, h};
            LSU_LHU: return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            op_q             <= LSU_NONE;
            alo_q            <= 2'b00;
            dmem_req_valid_q <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_we_q        <= 1'b0;
            dmem_be_q        <= 4'b0000;
            dmem_wdata_q     <= 32'h0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_data_q        <= 32'h0;
            wb_pc4_q         <= 32'h0;
            wb_rf_en_q       <= 1'b0;
            wb_sel_q         <= 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q       <= 1'b0;
`endif
        end else begin
            // wb_valid and misalign are one-cycle pulses.
            // They are cleared by default every cycle.
            wb_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        // Writeback context is captured up front for every op.
                        // Loads overwrite wb_data once the response arrives.
                        wb_rd_q   <= ex_out.rd;
                        wb_data_q <= ex_out.opr_res;
                        wb_pc4_q  <= ex_out.pc4;
                        wb_sel_q  <= ex_out.wb_sel;
                        if (!ex_out.dm_en) begin
                            wb_rf_en_q <= ex_out.rf_en;
                            wb_valid_q <= 1'b1;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (is_misaligned(ex_out.lsuop, ex_out.opr_res[1:0])) begin
                            wb_rf_en_q <= 1'b0;
                            wb_valid_q <= 1'b1;
                            misalign_q <= 1'b1;
                        end
`endif
                        else begin
                            op_q             <= ex_out.lsuop;
                            alo_q            <= ex_out.opr_res[1:0];
                            wb_rf_en_q       <= is_store(ex_out.lsuop) ? 1'b0 : ex_out.rf_en;
                            dmem_req_valid_q <= 1'b1;
                            dmem_addr_q      <= {ex_out.opr_res[DMEM_AW-1:2], 2'b00};
                            dmem_we_q        <= is_store(ex_out.lsuop);
                            dmem_be_q        <= store_be(ex_out.lsuop, ex_out.opr_res[1:0]);
                            dmem_wdata_q     <= store_wdata(ex_out.lsuop, ex_out.opr_b);
                            state_q          <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) begin
                        // Request fields return to zero so that IDLE/RSP present a quiet bus.
                        // Any response arriving in this same cycle is not looked at.
                        dmem_req_valid_q <= 1'b0;
                        dmem_addr_q      <= '0;
                        dmem_we_q        <= 1'b0;
                        dmem_be_q        <= 4'b0000;
                        dmem_wdata_q     <= 32'h0;
                        if (is_store(op_q)) begin
                            wb_valid_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            state_q    <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_data_q  <= load_data(op_q, alo_q, dmem_rsp_rdata);
                        wb_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ex_ready       = (state_q == S_IDLE);
    assign dmem_req_valid = dmem_req_valid_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_be        = dmem_be_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign wb_pc4         = wb_pc4_q;
    assign wb_rf_en       = wb_rf_en_q;
    assign wb_sel         = wb_sel_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign       = misalign_q;
`else
    assign misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized and directed bench for mem_stage with a behavioural writeback/request model
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid = 1'b0;
    ex_stage_out_t ex_out = '0;
    logic          ex_ready;
    logic          dmem_req_valid;
    logic          dmem_req_ready = 1'b0;
    logic [AW-1:0] dmem_addr;
    logic          dmem_we;
    logic [3:0]    dmem_be;
    logic [31:0]   dmem_wdata;
    logic          dmem_rsp_valid = 1'b0;
    logic [31:0]   dmem_rsp_rdata = 32'h0;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic [31:0]   wb_pc4;
    logic          wb_rf_en;
    logic [1:0]    wb_sel;
    logic          misalign;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_out(ex_out), .ex_ready(ex_ready),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc4(wb_pc4),
        .wb_rf_en(wb_rf_en), .wb_sel(wb_sel), .misalign(misalign)
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc4;
        logic        rf_en;
        logic [1:0]  sel;
        logic        mis;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    logic        busy = 1'b0;
    logic        exp_req_active = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_be = 4'h0;
    logic [31:0] exp_wdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on lanes, offsets and sign thresholds.
    function automatic logic [31:0] m_load(input lsuop_e op, input logic [1:0] a, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * a);
        case (op)
            LSU_LB:  begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            LSU_LBU: v = v % 256;
            LSU_LH:  begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
            LSU_LHU: v = v % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input lsuop_e op, input logic [1:0] a);
        int v;
        case (op)
            LSU_SB:  v = 1 << a;
            LSU_SH:  v = (3 << a) % 16;
            LSU_SW:  v = 15;
            default: v = 0;
        endcase
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input lsuop_e op, input logic [31:0] b);
        case (op)
            LSU_SB:  return (b % 256) * 32'h01010101;
            LSU_SH:  return (b % 65536) * 32'h00010001;
            LSU_SW:  return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_store(input lsuop_e op);
        return op == LSU_SB || op == LSU_SH || op == LSU_SW;
    endfunction

    function automatic logic m_mis(input lsuop_e op, input logic [1:0] a);
        if (op == LSU_LH || op == LSU_LHU || op == LSU_SH) return a % 2 == 1;
        if (op == LSU_LW || op == LSU_SW) return a != 0;
        return 1'b0;
    endfunction

    function automatic ex_stage_out_t mk(input lsuop_e op, input logic [4:0] rd,
                                         input logic [31:0] res, input logic [31:0] b);
        ex_stage_out_t x;
        x.rd      = rd;
        x.opr_b   = b;
        x.opr_res = res;
        x.pc4     = $urandom;
        x.lsuop   = op;
        x.rf_en   = (op == LSU_NONE) ? 1'($urandom_range(0, 1)) : 1'b1;
        x.dm_en   = (op != LSU_NONE);
        x.wb_sel  = 2'($urandom_range(0, 3));
        return x;
    endfunction

    task automatic push_exp(input int unsigned c, input ex_stage_out_t x, input logic [31:0] d,
                            input logic rf, input logic mis);
        wb_exp_t e;
        e.cyc   = c;
        e.rd    = x.rd;
        e.data  = d;
        e.pc4   = x.pc4;
        e.rf_en = rf;
        e.sel   = x.wb_sel;
        e.mis   = mis;
        exp_q.push_back(e);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after a rising edge.
    task automatic issue(input ex_stage_out_t x, input int rdy_dly, input int rsp_dly,
                         input logic [31:0] rdata, input bit rst_in_rsp);
        int unsigned c;
        logic        trap;
        logic        st;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = x.dm_en && m_mis(x.lsuop, x.opr_res[1:0]);
`else
        trap = 1'b0;
`endif
        st = m_store(x.lsuop);
        ex_valid = 1'b1;
        ex_out   = x;
        c        = cyc;
        if (!x.dm_en || trap) begin
            push_exp(c + 1, x, x.opr_res, x.dm_en ? 1'b0 : x.rf_en, trap);
            @(posedge clk); #1;
            ex_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ex_valid       = 1'b0;
        ex_out         = mk(lsuop_e'($urandom_range(0, 8)), 5'($urandom), $urandom, $urandom);
        busy           = 1'b1;
        exp_req_active = 1'b1;
        exp_addr       = (x.opr_res / 4) * 4;
        exp_we         = st;
        exp_be         = st ? m_be(x.lsuop, x.opr_res[1:0]) : 4'h0;
        exp_wdata      = m_wdata(x.lsuop, x.opr_b);
        repeat (rdy_dly) begin
            dmem_req_ready = 1'b0;
            @(posedge clk); #1;
        end
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rsp_rdata = $urandom;
        c = cyc;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        exp_req_active = 1'b0;
        if (st) begin
            push_exp(c + 1, x, x.opr_res, 1'b0, 1'b0);
            busy = 1'b0;
            return;
        end
        if (rst_in_rsp) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            busy  = 1'b0;
            check("rst_rsp_wb_valid", wb_valid, 1'b0);
            check("rst_rsp_ex_ready", ex_ready, 1'b1);
            check("rst_rsp_wb_data", wb_data, 32'h0);
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = rdata;
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
            check("rst_rsp_late_rsp_wb", wb_valid, 1'b0);
            check("rst_rsp_late_rsp_ready", ex_ready, 1'b1);
            return;
        end
        repeat (rsp_dly) begin
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
        push_exp(cyc + 1, x, m_load(x.lsuop, x.opr_res[1:0], rdata), x.rf_en, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        busy = 1'b0;
    endtask

    // Cycle-by-cycle compare against the model state, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ex_ready", ex_ready, !busy);
            if (exp_req_active) begin
                check("req_valid", dmem_req_valid, 1'b1);
                check("req_addr", dmem_addr, exp_addr);
                check("req_we", dmem_we, exp_we);
                check("req_be", dmem_be, exp_be);
                check("req_wdata", dmem_wdata, exp_wdata);
            end else begin
                check("req_valid_idle", dmem_req_valid, 1'b0);
            end
            if (ex_ready) begin
                check("idle_addr", dmem_addr, 32'h0);
                check("idle_we_be", {dmem_we, dmem_be}, 5'h0);
                check("idle_wdata", dmem_wdata, 32'h0);
            end
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("wb_spurious", wb_valid, 1'b0);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    check("wb_cycle", cyc, e.cyc);
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_data", wb_data, e.data);
                    check("wb_pc4", wb_pc4, e.pc4);
                    check("wb_rf_en", wb_rf_en, e.rf_en);
                    check("wb_sel", wb_sel, e.sel);
                    check("misalign", misalign, e.mis);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("wb_missing", wb_valid, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        lsuop_e op;
        ex_stage_out_t x;

        // Model pins, hand-computed.
        check("pin_sb_be", m_be(LSU_SB, 2'd3), 4'b1000);
        check("pin_sh_be_trunc", m_be(LSU_SH, 2'd3), 4'b1000);
        check("pin_sb_wdata", m_wdata(LSU_SB, 32'h000000AB), 32'hABABABAB);
        check("pin_sh_wdata", m_wdata(LSU_SH, 32'h1234BEEF), 32'hBEEFBEEF);
        check("pin_lb", m_load(LSU_LB, 2'd2, 32'h00800000), 32'hFFFFFF80);
        check("pin_lbu", m_load(LSU_LBU, 2'd2, 32'h00800000), 32'h00000080);
        check("pin_lh", m_load(LSU_LH, 2'd2, 32'h80010000), 32'hFFFF8001);
        check("pin_lw_mis", m_mis(LSU_LW, 2'd1), 1'b1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_req_valid", dmem_req_valid, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_wb_rf_en", wb_rf_en, 1'b0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_pc4", wb_pc4, 32'h0);
        check("rst_wb_sel", wb_sel, 2'd0);
        check("rst_ex_ready", ex_ready, 1'b1);

        // Directed cases.
        issue(mk(LSU_NONE, 5'd5, 32'h1234, 32'h0), 0, 0, 32'h0, 1'b0);
        issue(mk(LSU_SB, 5'd1, 32'h103, 32'hAB), 3, 0, 32'h0, 1'b0);
        issue(mk(LSU_LB, 5'd2, 32'h102, 32'h0), 0, 2, 32'h00800000, 1'b0);
        issue(mk(LSU_LBU, 5'd3, 32'h102, 32'h0), 1, 2, 32'h00800000, 1'b0);
        issue(mk(LSU_LH, 5'd4, 32'h2, 32'h0), 0, 0, 32'h80010000, 1'b0);
        issue(mk(LSU_LW, 5'd6, 32'h1, 32'h0), 0, 1, 32'hCAFEF00D, 1'b0);
        issue(mk(LSU_SH, 5'd7, 32'h203, 32'h1234BEEF), 1, 0, 32'h0, 1'b0);
        issue(mk(LSU_LB, 5'd8, 32'h40, 32'h0), 0, 0, 32'h12345678, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Randomized mix with back-to-back ALU ops and idle gaps.
        for (int i = 0; i < 300; i++) begin
            op = lsuop_e'($urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) op = LSU_NONE;
            x = mk(op, 5'($urandom), $urandom, $urandom);
            issue(x, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                ex_out = mk(lsuop_e'($urandom_range(0, 8)), 5'($urandom), $urandom, $urandom);
                dmem_rsp_valid = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                dmem_rsp_valid = 1'b0;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("wb_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DMEM_AW, default 32, data-memory byte-address width; dmem_addr is the low DMEM_AW bits of opr_res.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have ports: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: ex_valid  input  1  ex_out holds a valid instruction.
REQ-005 SHALL have ports: ex_out  input  ex_stage_out_t  fields rd, opr_b (store data), opr_res (address/result), pc4, lsuop, rf_en, dm_en, wb_sel.
REQ-006 SHALL have ports: ex_ready  output  1  stage can accept ex_out this cycle.
REQ-007 SHALL have ports: dmem_req_valid/dmem_req_ready  output/input  1/1  request handshake.
REQ-008 SHALL have ports: dmem_addr, dmem_we, dmem_be, dmem_wdata  output  DMEM_AW/1/4/32  word-aligned address, write enable, byte enables, lane-shifted store data.
REQ-009 SHALL have ports: dmem_rsp_valid, dmem_rsp_rdata  input  1/32  load response.
REQ-010 SHALL have ports: wb_valid, wb_rd, wb_data, wb_pc4, wb_rf_en, wb_sel  output  1/5/32/32/1/2  writeback bundle.
REQ-011 SHALL have ports: misalign  output  1  misaligned-access flag, valid with wb_valid.

Function
REQ-012 SHALL implement FSM IDLE, REQ, RSP; ex_ready = 1 only in IDLE.
REQ-013 IDLE, ex_valid=1, dm_en=0: SHALL register the bundle with wb_data=opr_res and pulse wb_valid for exactly one cycle on the next edge (latency 1), remaining in IDLE.
REQ-014 IDLE, ex_valid=1, dm_en=1: SHALL latch ex_out and move to REQ; no wb_valid that cycle.
REQ-015 REQ: dmem_req_valid=1 with all request fields stable until dmem_req_ready=1; no field may change while valid is high and ready low.
REQ-016 REQ with handshake, store (SB/SH/SW): SHALL return to IDLE and pulse wb_valid next edge with wb_rf_en=0.
REQ-017 REQ with handshake, load (LB/LH/LW/LBU/LHU): SHALL move to RSP; dmem_rsp_valid in the handshake cycle itself is ignored.
REQ-018 RSP, dmem_rsp_valid=1: SHALL select the byte/half by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), drive wb_data, pulse wb_valid, and return to IDLE.
REQ-019 Stores: dmem_be = 0001<<a[1:0] (SB), 0011<<a[1:0] (SH), 1111 (SW); dmem_wdata = opr_b replicated into lanes (SB {4{b}}, SH {2{h}}).
REQ-020 dmem_addr SHALL be opr_res with bits [1:0] forced to 0.
REQ-021 wb_valid SHALL never be high two consecutive cycles for one instruction; WB has no backpressure.
REQ-022 Outside REQ, dmem_req_valid SHALL be 0; in IDLE all dmem outputs SHALL be 0.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force IDLE; wb_valid, dmem_req_valid, misalign, wb_rf_en = 0; wb_data, wb_rd, wb_pc4, wb_sel = 0; ex_ready = 1 once rst_n=1.
REQ-024 Reset during REQ or RSP SHALL abandon the transaction; late dmem_rsp_valid after reset is ignored in IDLE.

Configuration
REQ-025 Macro MEM_MISALIGN_TRAP_EN: when defined, a halfword at addr[0]=1 or word at addr[1:0]!=0 SHALL skip REQ, pulse wb_valid next edge with misalign=1, wb_rf_en=0, no dmem request.
REQ-026 When undefined, misalign SHALL be tied 0 and misaligned accesses proceed with the lane/byte-enable rules of REQ-019 (bytes truncated at word boundary).

Verification
REQ-027 ALU op rd=5, opr_res=0x1234, dm_en=0 -> wb_valid one cycle later, wb_data=0x1234, wb_rd=5, no dmem_req_valid.
REQ-028 SB addr=0x103, opr_b=0xAB, dmem_req_ready low 3 cycles -> dmem_req_valid held 4 cycles stable, addr=0x100, be=1000, wdata=0xABABABAB, ex_ready=0 throughout.
REQ-029 LB addr=0x102, rsp rdata=0x00800000 after 2 cycles -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 LH addr=0x2 rdata=0x80010000 -> wb_data=0xFFFF8001; LW addr=0x1 with macro -> misalign=1, no request; without macro -> request addr=0x0.
REQ-031 rst_n low in RSP, then rsp_valid arrives -> no wb_valid, state IDLE, ex_ready=1.
